// File: rtl/ir_pkg.sv
// Shared IR link definitions: frame FSM states and default carrier/frame timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_MRK,
        HDR_SPC,
        BIT_MRK,
        BIT_SPC,
        STOP_MRK,
        DONE
    } ir_state_e;

    localparam int DEF_CLK_HZ     = 50_000_000;
    localparam int DEF_CARRIER_HZ = 38_000;
    localparam int DEF_HDR_MARK   = 16;
    localparam int DEF_HDR_SPACE  = 8;
    localparam int DEF_BIT_MARK   = 4;
    localparam int DEF_ZERO_SPACE = 4;
    localparam int DEF_ONE_SPACE  = 12;
    localparam int DEF_STOP_MARK  = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier: phase high for HALF cycles, low for HALF, tick on last cycle of each period.
// Latency: restart gives counter=0, phase high on the following cycle.
// Backpressure: none; free-running.
module ir_carrier_gen #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic phase,
    output logic tick
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt;
    logic          at_end;

    assign at_end = (cnt == CW'(HALF - 1));
    // Tick marks the cycle right before phase goes low->high, i.e. a period boundary.
    assign tick   = at_end & ~phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (at_end) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ir_beam_emitter.sv
// IR break-beam emitter: continuous carrier while idle, pulse-distance coded 8-bit frames on request.
// Latency: ir_led/busy assert the cycle after an accepted tx_start; tx_done one cycle after the last stop period.
// Backpressure: tx_start is dropped while busy; no queuing.
module ir_beam_emitter
    import ir_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int CARRIER_HZ = DEF_CARRIER_HZ,
    parameter int HDR_MARK   = DEF_HDR_MARK,
    parameter int HDR_SPACE  = DEF_HDR_SPACE,
    parameter int BIT_MARK   = DEF_BIT_MARK,
    parameter int ZERO_SPACE = DEF_ZERO_SPACE,
    parameter int ONE_SPACE  = DEF_ONE_SPACE,
    parameter int STOP_MARK  = DEF_STOP_MARK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       ir_led,
    output logic       busy,
    output logic       tx_done
);

    localparam int HALF    = CLK_HZ / (2 * CARRIER_HZ);
    localparam int MAX_DUR = max2(max2(max2(HDR_MARK, HDR_SPACE), max2(BIT_MARK, ZERO_SPACE)),
                                  max2(ONE_SPACE, STOP_MARK));
    localparam int CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

    if (HALF < 1) begin : g_bad_half
        $error("ir_beam_emitter: CLK_HZ too low for CARRIER_HZ (HALF < 1)");
    end
    if (HDR_MARK < 1 || HDR_SPACE < 1 || BIT_MARK < 1 ||
        ZERO_SPACE < 1 || ONE_SPACE < 1 || STOP_MARK < 1) begin : g_bad_dur
        $error("ir_beam_emitter: every frame segment must last at least one carrier period");
    end

    ir_state_e        state;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] seg_last;
    logic [2:0]       bit_idx;
    logic [7:0]       data;
    logic             phase;
    logic             tick;
    logic             accept;

    assign accept = tx_start && (state == IDLE || state == DONE);

    ir_carrier_gen #(
        .HALF (HALF < 1 ? 1 : HALF)
    ) u_carrier (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .phase   (phase),
        .tick    (tick)
    );

    // Index of the final carrier period of the current segment.
    always_comb begin
        seg_last = '0;
        case (state)
            HDR_MRK:  seg_last = CNT_W'(HDR_MARK - 1);
            HDR_SPC:  seg_last = CNT_W'(HDR_SPACE - 1);
            BIT_MRK:  seg_last = CNT_W'(BIT_MARK - 1);
            BIT_SPC:  seg_last = data[3'd7 - bit_idx] ? CNT_W'(ONE_SPACE - 1) : CNT_W'(ZERO_SPACE - 1);
            STOP_MRK: seg_last = CNT_W'(STOP_MARK - 1);
            default:  seg_last = '0;
        endcase
    end

    // The LED is a pure decode of registered carrier/FSM state; en only matters outside a frame.
    always_comb begin
        case (state)
            HDR_MRK, BIT_MRK, STOP_MRK: ir_led = phase;
            HDR_SPC, BIT_SPC:           ir_led = 1'b0;
            default:                    ir_led = en & phase;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            per_cnt <= '0;
            bit_idx <= '0;
            data    <= '0;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    per_cnt <= '0;
                    bit_idx <= '0;
                    if (tx_start) begin
                        data  <= tx_data;
                        state <= HDR_MRK;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    if (tick) begin
                        if (per_cnt != seg_last) begin
                            per_cnt <= per_cnt + 1'b1;
                        end else begin
                            per_cnt <= '0;
                            case (state)
                                HDR_MRK: state <= HDR_SPC;
                                HDR_SPC: state <= BIT_MRK;
                                BIT_MRK: state <= BIT_SPC;
                                BIT_SPC: begin
                                    if (bit_idx == 3'd7) begin
                                        state <= STOP_MRK;
                                    end else begin
                                        bit_idx <= bit_idx + 1'b1;
                                        state   <= BIT_MRK;
                                    end
                                end
                                default: begin
                                    state   <= DONE;
                                    busy    <= 1'b0;
                                    tx_done <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
